// File: rtl/zoom_in_if.sv
// Pixel-stream bundle between the VGA timing side, the source frame
// memory and the zoom engine.
interface zoom_in_if #(
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int DATA_WIDTH = 8
);
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   logic                  flow_enabled;
   logic                  algorithm_select;
   logic [1:0]            k;
   logic [9:0]            x_vga;
   logic [9:0]            y_vga;
   logic [XW-1:0]         mem_x_addr;
   logic [YW-1:0]         mem_y_addr;
   logic [DATA_WIDTH-1:0] mem_pixel_in;
   logic [DATA_WIDTH-1:0] pixel_out;
   logic                  pixel_valid;

   modport master (
      output flow_enabled, algorithm_select, k, x_vga, y_vga,
      output mem_pixel_in,
      input  mem_x_addr, mem_y_addr, pixel_out, pixel_valid
   );

   modport slave (
      input  flow_enabled, algorithm_select, k, x_vga, y_vga,
      input  mem_pixel_in,
      output mem_x_addr, mem_y_addr, pixel_out, pixel_valid
   );
endinterface

// File: rtl/zoom_in.sv
// 2^k image upscaler: pixel replication, or bilinear interpolation
// built from four sequential reads of a 2-cycle-latency frame memory.
module zoom_in #(
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   zoom_in_if.slave   bus
);
   localparam int XW   = $clog2(IMG_WIDTH);
   localparam int YW   = $clog2(IMG_HEIGHT);
   localparam int ACCW = DATA_WIDTH + 7;
   localparam logic [9:0] XMAX = 10'(IMG_WIDTH - 1);
   localparam logic [9:0] YMAX = 10'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, CALC} state_t;

   state_t                state_q;
   logic                  lock_valid_q;
   logic [9:0]            lx_q, ly_q;
   logic [XW-1:0]         sx_q;
   logic [YW-1:0]         sy_q;
   logic [2:0]            fx_q, fy_q;
   logic [1:0]            k_q;
   logic [1:0]            idx_q;
   logic [ACCW-1:0]       acc_q;
   logic                  rv1_q, rv2_q, fe1_q, fe2_q;
   logic                  bv1_q, bv2_q;
   logic [1:0]            bi1_q, bi2_q;
   logic [XW-1:0]         mx_q;
   logic [YW-1:0]         my_q;
   logic [DATA_WIDTH-1:0] pix_q;
   logic                  valid_q;

   logic                  bil, trig, abort;
   logic [9:0]            xs, ys;
   logic [XW-1:0]         sx_d, x1, ax;
   logic [YW-1:0]         sy_d, y1, ay;
   logic [2:0]            fmask, fx_d, fy_d;
   logic [3:0]            wfull, wx, wy;
   logic [7:0]            wgt;
   logic [ACCW-1:0]       acc_d;
   logic [2:0]            sh;
   logic [ACCW:0]         rsum;
   logic [DATA_WIDTH-1:0] rnd;

   always_comb begin
      bil   = bus.algorithm_select && (bus.k != 2'd0);
      xs    = bus.x_vga >> bus.k;
      ys    = bus.y_vga >> bus.k;
      sx_d  = (xs > XMAX) ? XMAX[XW-1:0] : xs[XW-1:0];
      sy_d  = (ys > YMAX) ? YMAX[YW-1:0] : ys[YW-1:0];
      fmask = (3'd1 << bus.k) - 3'd1;
      fx_d  = bus.x_vga[2:0] & fmask;
      fy_d  = bus.y_vga[2:0] & fmask;
      trig  = bil && bus.flow_enabled &&
              (!lock_valid_q || bus.x_vga != lx_q || bus.y_vga != ly_q);
      abort = (state_q != IDLE) && (!bil || bus.k != k_q);
      x1    = (sx_q == XMAX[XW-1:0]) ? sx_q : sx_q + 1'b1;
      y1    = (sy_q == YMAX[YW-1:0]) ? sy_q : sy_q + 1'b1;
      ax    = idx_q[0] ? x1 : sx_q;
      ay    = idx_q[1] ? y1 : sy_q;
      // weight for the sample whose data is arriving this cycle
      wfull = 4'd1 << k_q;
      wx    = bi2_q[0] ? {1'b0, fx_q} : wfull - {1'b0, fx_q};
      wy    = bi2_q[1] ? {1'b0, fy_q} : wfull - {1'b0, fy_q};
      wgt   = {4'd0, wx} * {4'd0, wy};
      acc_d = acc_q + ACCW'(bus.mem_pixel_in) * ACCW'(wgt);
      sh    = {k_q, 1'b0};
      rsum  = {1'b0, acc_q} + ((ACCW+1)'(1) << (sh - 3'd1));
      rnd   = DATA_WIDTH'(rsum >> sh);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         lock_valid_q <= 1'b0;
         lx_q         <= '0;
         ly_q         <= '0;
         sx_q         <= '0;
         sy_q         <= '0;
         fx_q         <= '0;
         fy_q         <= '0;
         k_q          <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
         rv1_q        <= 1'b0;
         rv2_q        <= 1'b0;
         fe1_q        <= 1'b0;
         fe2_q        <= 1'b0;
         bv1_q        <= 1'b0;
         bv2_q        <= 1'b0;
         bi1_q        <= '0;
         bi2_q        <= '0;
         mx_q         <= '0;
         my_q         <= '0;
         pix_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         rv1_q   <= !bil;
         rv2_q   <= rv1_q;
         fe1_q   <= bus.flow_enabled;
         fe2_q   <= fe1_q;
         bv1_q   <= 1'b0;
         bi1_q   <= idx_q;
         bv2_q   <= bv1_q;
         bi2_q   <= bi1_q;
         valid_q <= 1'b0;
         if (rv2_q) begin
            pix_q   <= bus.mem_pixel_in;
            valid_q <= fe2_q;
         end
         if (bv2_q) acc_q <= acc_d;
         if (!bil) begin
            mx_q <= sx_d;
            my_q <= sy_d;
         end
         if (abort) begin
            state_q      <= IDLE;
            lock_valid_q <= 1'b0;
            bv2_q        <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: if (trig) begin
                  lock_valid_q <= 1'b1;
                  lx_q         <= bus.x_vga;
                  ly_q         <= bus.y_vga;
                  sx_q         <= sx_d;
                  sy_q         <= sy_d;
                  fx_q         <= fx_d;
                  fy_q         <= fy_d;
                  k_q          <= bus.k;
                  acc_q        <= '0;
                  idx_q        <= '0;
                  state_q      <= FETCH;
               end
               FETCH: begin
                  mx_q  <= ax;
                  my_q  <= ay;
                  bv1_q <= 1'b1;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) state_q <= DRAIN;
               end
               DRAIN: begin
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd1) state_q <= CALC;
               end
               CALC: begin
                  pix_q   <= rnd;
                  valid_q <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.mem_x_addr  = mx_q;
   assign bus.mem_y_addr  = my_q;
   assign bus.pixel_out   = pix_q;
   assign bus.pixel_valid = valid_q;
endmodule

// File: tb/tb_zoom_in.sv
// Directed bench for zoom_in: a frame-memory model with 2-cycle read
// latency and a scoreboard of expected pixel pulses with due cycles.
module tb_zoom_in;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   cmode = 1'b0;
   int   cval = 0;

   typedef struct {
      int    val;
      int    due;
      string tag;
   } exp_t;
   exp_t sb[$];

   zoom_in_if #(.IMG_WIDTH(160), .IMG_HEIGHT(120), .DATA_WIDTH(8)) bus();

   zoom_in #(.IMG_WIDTH(160), .IMG_HEIGHT(120), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int pix(int x, int y);
      if (cmode) return cval;
      if (x == 1 && y == 0) return 100;
      if (x == 2 && y == 0) return 200;
      return (x * 7 + y * 13 + 5) % 256;
   endfunction

   function automatic int clampi(int v, int m);
      return (v > m) ? m : v;
   endfunction

   function automatic int rep_model(int x, int y, int kk);
      return pix(clampi(x >> kk, 159), clampi(y >> kk, 119));
   endfunction

   function automatic int bil_model(int x, int y, int kk);
      int w, sx, sy, x1, y1, fx, fy, acc;
      w   = 1 << kk;
      sx  = clampi(x >> kk, 159);
      sy  = clampi(y >> kk, 119);
      x1  = clampi(sx + 1, 159);
      y1  = clampi(sy + 1, 119);
      fx  = x % w;
      fy  = y % w;
      acc = pix(sx, sy) * (w - fx) * (w - fy) + pix(x1, sy) * fx * (w - fy)
          + pix(sx, y1) * (w - fx) * fy + pix(x1, y1) * fx * fy;
      return (acc + (1 << (2 * kk - 1))) >> (2 * kk);
   endfunction

   always @(posedge clk)
      bus.mem_pixel_in <= 8'(pix(int'(bus.mem_x_addr), int'(bus.mem_y_addr)));

   task automatic chk(string tag, int obs, int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && bus.pixel_valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse observed=%0d expected=none",
                   bus.pixel_out);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_val"}, int'(bus.pixel_out), e.val);
            chk({e.tag, "_cyc"}, cyc, e.due);
         end
      end
      if (sb.size() != 0 && sb[0].due < cyc) begin
         checks++;
         assert (sb[0].due >= cyc) else begin
            errors++;
            $error("FAIL %s_missing observed=none expected=%0d at cycle %0d",
                   sb[0].tag, sb[0].val, sb[0].due);
         end
         void'(sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(bit fe, bit alg, int kk, int x, int y);
      bus.flow_enabled     = fe;
      bus.algorithm_select = alg;
      bus.k                = 2'(kk);
      bus.x_vga            = 10'(x);
      bus.y_vga            = 10'(y);
   endtask

   task automatic push(string tag, int v, int due);
      exp_t e;
      e.val = v;
      e.due = due;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic chk_addr(string tag, int ex, int ey);
      @(negedge clk);
      chk({tag, "_x"}, int'(bus.mem_x_addr), ex);
      chk({tag, "_y"}, int'(bus.mem_y_addr), ey);
   endtask

   task automatic chk_zero(string tag);
      @(negedge clk);
      chk({tag, "_px"}, int'(bus.pixel_out), 0);
      chk({tag, "_pv"}, int'(bus.pixel_valid), 0);
      chk({tag, "_mx"}, int'(bus.mem_x_addr), 0);
      chk({tag, "_my"}, int'(bus.mem_y_addr), 0);
   endtask

   task automatic run_bil(string tag, int x, int y, int kk);
      drv(1, 1, kk, x, y);
      push(tag, bil_model(x, y, kk), cyc + 8);
      tick();
      drv(0, 1, kk, x, y);
      repeat (9) tick();
   endtask

   initial begin
      int t;
      drv(0, 1, 1, 0, 0);
      tick();
      tick();
      chk_zero("reset");
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk_zero("idle");

      // replication, k=1
      cmode = 1'b1;
      cval  = 8'h40;
      drv(1, 0, 1, 10, 6);
      push("rep032", 8'h40, cyc + 3);
      tick();
      drv(0, 0, 1, 10, 6);
      chk_addr("rep032_addr", 5, 3);
      repeat (4) tick();

      // replication at k=0 with clamp, and k=0 forcing replication
      cmode = 1'b0;
      drv(1, 0, 0, 200, 130);
      push("rep_clamp", rep_model(200, 130, 0), cyc + 3);
      tick();
      drv(0, 0, 0, 200, 130);
      chk_addr("rep_clamp_addr", 159, 119);
      repeat (4) tick();
      drv(1, 1, 0, 7, 9);
      push("rep_k0", rep_model(7, 9, 0), cyc + 3);
      tick();
      drv(0, 1, 0, 7, 9);
      repeat (4) tick();

      // back-to-back replication
      drv(1, 0, 2, 40, 20);
      push("rep_b2b0", rep_model(40, 20, 2), cyc + 3);
      tick();
      drv(1, 0, 2, 44, 24);
      push("rep_b2b1", rep_model(44, 24, 2), cyc + 3);
      tick();
      drv(0, 0, 2, 44, 24);
      repeat (4) tick();

      // bilinear k=1 directed
      drv(1, 1, 1, 3, 0);
      t = cyc;
      push("bil033", 150, t + 8);
      tick();
      drv(0, 1, 1, 3, 0);
      tick();
      chk_addr("bil033_a0", 1, 0);
      tick();
      chk_addr("bil033_a1", 2, 0);
      tick();
      chk_addr("bil033_a2", 1, 1);
      tick();
      chk_addr("bil033_a3", 2, 1);
      repeat (5) tick();
      @(negedge clk);
      chk("bil033_hold_px", int'(bus.pixel_out), 150);
      chk("bil033_hold_pv", int'(bus.pixel_valid), 0);
      tick();

      // bilinear edge clamp, constant memory
      cmode = 1'b1;
      cval  = 77;
      drv(1, 1, 2, 639, 479);
      push("bil034", 77, cyc + 8);
      tick();
      drv(0, 1, 2, 639, 479);
      tick();
      chk_addr("bil034_a0", 159, 119);
      tick();
      chk_addr("bil034_a1", 159, 119);
      tick();
      chk_addr("bil034_a2", 159, 119);
      tick();
      chk_addr("bil034_a3", 159, 119);
      repeat (6) tick();

      cmode = 1'b0;
      run_bil("bil_k2", 37, 22, 2);
      run_bil("bil_k3", 100, 51, 3);
      run_bil("bil_edge", 319, 239, 1);

      // abort by switching to replication mid-FETCH
      drv(1, 1, 1, 20, 20);
      t = cyc;
      tick();
      drv(0, 1, 1, 20, 20);
      tick();
      drv(1, 0, 1, 20, 20);
      push("abort_rep", rep_model(20, 20, 1), cyc + 3);
      tick();
      drv(0, 0, 1, 20, 20);
      chk_addr("abort_addr", 10, 10);
      while (cyc < t + 8) tick();
      @(negedge clk);
      chk("abort_nopulse", int'(bus.pixel_valid), 0);
      tick();
      drv(0, 1, 1, 20, 20);
      repeat (3) tick();

      // reset during the second FETCH cycle
      drv(1, 1, 1, 50, 40);
      t = cyc;
      tick();
      drv(0, 1, 1, 50, 40);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("midreset");
      while (cyc < t + 8) tick();
      @(negedge clk);
      chk("midreset_nopulse", int'(bus.pixel_valid), 0);
      repeat (4) tick();

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
